// File: rtl/aes_dec_pack_512.sv
// Packs 128-bit AES plaintext blocks into 512-bit words and buffers them in a
// first-word-fall-through FIFO; words that find the FIFO full are dropped and flagged.
module aes_dec_pack_512 #(
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [127:0]                  in_data,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [511:0]                  out_data,
  output logic [3:0]                    out_keep,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          almost_full,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic [3:0][127:0] lanes_q, lanes_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push;
  logic [511:0]      push_data;
  logic [3:0]        push_keep;

  logic [515:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              almost_full_q, overflow_q;
  logic              pop, wr_en, drop;
  logic [515:0]      head;

  // Keep mask for a word whose highest filled lane is `last`.
  function automatic logic [3:0] keep_for(input logic [1:0] last);
    case (last)
      2'd0:    keep_for = 4'b0001;
      2'd1:    keep_for = 4'b0011;
      2'd2:    keep_for = 4'b0111;
      default: keep_for = 4'b1111;
    endcase
  endfunction

  // The incoming block is merged before closing, so flush with cnt==3 yields one full word.
  always_comb begin
    lanes_d   = lanes_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = '0;
    push_keep = '0;
    if (in_valid) begin
      lanes_d[cnt_q] = in_data;
      if (cnt_q == 2'd3 || flush) begin
        push      = 1'b1;
        push_data = lanes_d;
        push_keep = keep_for(cnt_q);
        lanes_d   = '0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else if (flush && cnt_q != 2'd0) begin
      push      = 1'b1;
      push_data = lanes_q;
      push_keep = keep_for(cnt_q - 2'd1);
      lanes_d   = '0;
      cnt_d     = '0;
    end
  end

  assign pop   = (count_q != '0) && out_ready;
  assign wr_en = push && ((count_q < DEPTH_C) || pop);
  assign drop  = push && !wr_en;

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q       <= '0;
      cnt_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      lanes_q       <= lanes_d;
      cnt_q         <= cnt_d;
      count_q       <= count_d;
      almost_full_q <= (count_d >= AF_C);
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (pop)   rptr_q <= rptr_q + AW'(1);
      if (drop)  overflow_q <= 1'b1;
    end
  end

  // Storage is not reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wptr_q] <= {push_keep, push_data};
  end

  assign head        = mem_q[rptr_q];
  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? head[511:0]   : '0;
  assign out_keep    = out_valid ? head[515:512] : '0;
  assign fill_level  = count_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_aes_dec_pack_512.sv
// Directed bench for aes_dec_pack_512: per-cycle vector table plus FIFO
// full/overflow/reset sequences.
module tb_aes_dec_pack_512;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         flush;
  logic         out_valid;
  logic [511:0] out_data;
  logic [3:0]   out_keep;
  logic         out_ready;
  logic [3:0]   fill_level;
  logic         almost_full;
  logic         overflow;

  int unsigned checks = 0;
  int unsigned failures = 0;

  aes_dec_pack_512 #(.FIFO_DEPTH(8), .AF_THRESH(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
    .out_ready(out_ready), .fill_level(fill_level), .almost_full(almost_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [127:0] d;
    logic         f;
    logic         r;
    logic         ev;
    logic [511:0] ed;
    logic [3:0]   ek;
    logic [3:0]   efl;
  } vec_t;

  vec_t tbl [21];

  function automatic logic [511:0] w4(input logic [127:0] l0, l1, l2, l3);
    w4 = {l3, l2, l1, l0};
  endfunction

  // Word w of the sequences: lane n holds w*16+n.
  function automatic logic [511:0] wd(input int unsigned w);
    wd = w4(128'(w * 16 + 0), 128'(w * 16 + 1), 128'(w * 16 + 2), 128'(w * 16 + 3));
  endfunction

  function automatic vec_t mk(input logic v, input logic [127:0] d, input logic f,
                              input logic ev, input logic [511:0] ed, input logic [3:0] ek,
                              input logic [3:0] efl);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.r = 1'b1;
    t.ev = ev; t.ed = ed; t.ek = ek; t.efl = efl;
    mk = t;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle with the given inputs; returns #1 after the edge.
  task automatic cyc(input logic v, input logic [127:0] d, input logic f, input logic r);
    in_valid = v; in_data = d; flush = f; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int unsigned w, input logic r_last);
    for (int unsigned n = 0; n < 4; n++)
      cyc(1'b1, 128'(w * 16 + n), 1'b0, (n == 3) ? r_last : 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned first, input int unsigned last);
    for (int unsigned w = first; w <= last; w++) begin
      chk($sformatf("drain_valid_w%0d", w), 512'(out_valid), 512'(1));
      chk($sformatf("drain_data_w%0d", w), out_data, wd(w));
      chk($sformatf("drain_keep_w%0d", w), 512'(out_keep), 512'(4'hF));
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
    chk("drain_empty", 512'(out_valid), 512'(0));
    chk("drain_fill0", 512'(fill_level), 512'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 512'(out_valid), 512'(0));
    chk({tag, "_data"}, out_data, 512'(0));
    chk({tag, "_keep"}, 512'(out_keep), 512'(0));
    chk({tag, "_fill"}, 512'(fill_level), 512'(0));
    chk({tag, "_af"}, 512'(almost_full), 512'(0));
    chk({tag, "_ovf"}, 512'(overflow), 512'(0));
  endtask

  initial begin
    tbl[0]  = mk(1, 128'h1,  0, 0, '0, 4'h0, 4'd0);
    tbl[1]  = mk(1, 128'h2,  0, 0, '0, 4'h0, 4'd0);
    tbl[2]  = mk(1, 128'h3,  0, 0, '0, 4'h0, 4'd0);
    tbl[3]  = mk(1, 128'h4,  0, 1, w4(128'h1, 128'h2, 128'h3, 128'h4), 4'hF, 4'd1);
    tbl[4]  = mk(0, 128'h0,  0, 0, '0, 4'h0, 4'd0);
    tbl[5]  = mk(1, 128'hA,  0, 0, '0, 4'h0, 4'd0);
    tbl[6]  = mk(1, 128'hB,  0, 0, '0, 4'h0, 4'd0);
    tbl[7]  = mk(0, 128'h0,  1, 1, w4(128'hA, 128'hB, '0, '0), 4'h3, 4'd1);
    tbl[8]  = mk(1, 128'h11, 0, 0, '0, 4'h0, 4'd0);
    tbl[9]  = mk(1, 128'h12, 0, 0, '0, 4'h0, 4'd0);
    tbl[10] = mk(1, 128'h13, 0, 0, '0, 4'h0, 4'd0);
    tbl[11] = mk(1, 128'h14, 0, 1, w4(128'h11, 128'h12, 128'h13, 128'h14), 4'hF, 4'd1);
    tbl[12] = mk(1, 128'h21, 0, 0, '0, 4'h0, 4'd0);
    tbl[13] = mk(1, 128'h22, 0, 0, '0, 4'h0, 4'd0);
    tbl[14] = mk(1, 128'h23, 1, 1, w4(128'h21, 128'h22, 128'h23, '0), 4'h7, 4'd1);
    tbl[15] = mk(1, 128'h31, 0, 0, '0, 4'h0, 4'd0);
    tbl[16] = mk(1, 128'h32, 0, 0, '0, 4'h0, 4'd0);
    tbl[17] = mk(1, 128'h33, 0, 0, '0, 4'h0, 4'd0);
    tbl[18] = mk(1, 128'h34, 1, 1, w4(128'h31, 128'h32, 128'h33, 128'h34), 4'hF, 4'd1);
    tbl[19] = mk(0, 128'h0,  0, 0, '0, 4'h0, 4'd0);
    tbl[20] = mk(0, 128'h0,  1, 0, '0, 4'h0, 4'd0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    for (int unsigned i = 0; i < 21; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      chk($sformatf("vec%0d_valid", i), 512'(out_valid), 512'(tbl[i].ev));
      chk($sformatf("vec%0d_fill", i), 512'(fill_level), 512'(tbl[i].efl));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_data", i), out_data, tbl[i].ed);
        chk($sformatf("vec%0d_keep", i), 512'(out_keep), 512'(tbl[i].ek));
      end
    end

    // FIFO full, push and pop on the same edge.
    for (int unsigned w = 1; w <= 8; w++) send_word(w, 1'b0);
    chk("pp_fill8", 512'(fill_level), 512'(8));
    chk("pp_af", 512'(almost_full), 512'(1));
    send_word(9, 1'b1);
    chk("pp_fill_hold", 512'(fill_level), 512'(8));
    chk("pp_no_ovf", 512'(overflow), 512'(0));
    drain(2, 9);

    // Stalled consumer: nine words, the ninth dropped.
    for (int unsigned w = 1; w <= 9; w++) begin
      send_word(w, 1'b0);
      chk($sformatf("of_fill_w%0d", w), 512'(fill_level), 512'((w < 8) ? w : 8));
      chk($sformatf("of_af_w%0d", w), 512'(almost_full), 512'(w >= 6));
      chk($sformatf("of_ovf_w%0d", w), 512'(overflow), 512'(w == 9));
    end
    chk("of_stall_data", out_data, wd(1));
    drain(1, 8);
    chk("of_sticky", 512'(overflow), 512'(1));

    // Reset with a stored word and a half-filled accumulator.
    send_word(5, 1'b0);
    cyc(1'b1, 128'h70, 1'b0, 1'b0);
    cyc(1'b1, 128'h71, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 128'h72, 1'b1, 1'b0);
    rst = 1'b0;
    chk_zero("midrst");
    cyc(1'b1, 128'h80, 1'b0, 1'b1);
    cyc(1'b1, 128'h81, 1'b0, 1'b1);
    cyc(1'b1, 128'h82, 1'b0, 1'b1);
    chk("midrst_partial", 512'(out_valid), 512'(0));
    cyc(1'b1, 128'h83, 1'b0, 1'b1);
    in_valid = 1'b0;
    chk("post_valid", 512'(out_valid), 512'(1));
    chk("post_data", out_data, w4(128'h80, 128'h81, 128'h82, 128'h83));
    chk("post_keep", 512'(out_keep), 512'(4'hF));
    chk("post_ovf", 512'(overflow), 512'(0));
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("post_empty", 512'(out_valid), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
